// File: rtl/fir_tap_sequencer.sv
// Tap-index down-counter that frames one FIR MAC sweep (N_TAPS-1 .. 0) per sample strobe.
// Optional sticky overrun flag for ignored starts: define FIR_SEQ_OVERRUN_EN.
module fir_tap_sequencer #(
   parameter int N_TAPS   = 8,
   parameter int FREE_RUN = 0,
   localparam int CW      = $clog2(N_TAPS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          enable,
`ifdef FIR_SEQ_OVERRUN_EN
   input  logic          ovr_clr,
   output logic          overrun,
`endif
   output logic [CW-1:0] contador,
   output logic          busy,
   output logic          first_tap,
   output logic          last_tap,
   output logic          done
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [CW-1:0] TOP = CW'(N_TAPS - 1);

   state_t          state, state_next;
   logic [CW-1:0]   cnt_next;
   logic            done_next;
   logic            terminal;

   assign terminal  = (contador == '0);
   assign first_tap = busy && (contador == TOP);
   assign last_tap  = busy && terminal;

   // NOTE: every output of this block gets a default first, so no path leaves a latch.
   always_comb begin
      state_next = state;
      cnt_next   = contador;
      done_next  = 1'b0;
      case (state)
         IDLE: begin
            cnt_next = TOP;
            if (start || (FREE_RUN != 0)) state_next = RUN;
         end
         RUN: begin
            if (enable) begin
               if (terminal) begin
                  // Reload instead of wrapping through codes above N_TAPS-1.
                  cnt_next  = TOP;
                  done_next = 1'b1;
                  if (!start && (FREE_RUN == 0)) state_next = IDLE;
               end else begin
                  cnt_next = contador - CW'(1);
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         contador <= TOP;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_next;
         contador <= cnt_next;
         busy     <= (state_next == RUN);
         done     <= done_next;
      end
   end

`ifdef FIR_SEQ_OVERRUN_EN
   logic ovr_set;

   // A start that cannot launch a sweep: mid-sweep, or while stalled.
   assign ovr_set = (FREE_RUN == 0) && (state == RUN) && start && (!terminal || !enable);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)        overrun <= 1'b0;
      else if (ovr_set) overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
   end
`endif

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench: one-shot sequencer (N_TAPS=8) and free-running sequencer (N_TAPS=5).
module tb_fir_tap_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       enable;
   logic       enable_b;
   logic [2:0] contador_a, contador_b;
   logic       busy_a, first_a, last_a, done_a;
   logic       busy_b, first_b, last_b, done_b;
`ifdef FIR_SEQ_OVERRUN_EN
   logic       ovr_clr;
   logic       overrun_a, overrun_b;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fir_tap_sequencer #(.N_TAPS(8), .FREE_RUN(0)) dut_a (
      .clk(clk), .reset(reset), .start(start), .enable(enable),
`ifdef FIR_SEQ_OVERRUN_EN
      .ovr_clr(ovr_clr), .overrun(overrun_a),
`endif
      .contador(contador_a), .busy(busy_a), .first_tap(first_a),
      .last_tap(last_a), .done(done_a)
   );

   fir_tap_sequencer #(.N_TAPS(5), .FREE_RUN(1)) dut_b (
      .clk(clk), .reset(reset), .start(start), .enable(enable_b),
`ifdef FIR_SEQ_OVERRUN_EN
      .ovr_clr(ovr_clr), .overrun(overrun_b),
`endif
      .contador(contador_b), .busy(busy_b), .first_tap(first_b),
      .last_tap(last_b), .done(done_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_a(input string tag, input int cnt, input bit bsy, input bit dn);
      check({tag, ".contador"}, 32'(contador_a), 32'(cnt));
      check({tag, ".busy"}, 32'(busy_a), 32'(bsy));
      check({tag, ".done"}, 32'(done_a), 32'(dn));
      check({tag, ".first_tap"}, 32'(first_a), 32'(bsy && cnt == 7));
      check({tag, ".last_tap"}, 32'(last_a), 32'(bsy && cnt == 0));
   endtask

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      enable   = 1'b1;
      enable_b = 1'b1;
`ifdef FIR_SEQ_OVERRUN_EN
      ovr_clr  = 1'b0;
`endif
      #12;
      check_a("reset", 7, 0, 0);
      check("reset.b_busy", 32'(busy_b), 32'd0);
      check("reset.b_cnt", 32'(contador_b), 32'd4);

      // Free-running instance: 4,3,2,1,0,4,... with done on each wrap; one start pulse injected.
      @(posedge clk); #1 reset = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         start = (k == 3);
         tick();
         start = 1'b0;
         check($sformatf("free[%0d].cnt", k), 32'(contador_b), 32'(4 - ((k - 1) % 5)));
         check($sformatf("free[%0d].done", k), 32'(done_b),
               32'((k > 1) && ((k - 1) % 5 == 0)));
         check($sformatf("free[%0d].busy", k), 32'(busy_b), 32'd1);
      end
`ifdef FIR_SEQ_OVERRUN_EN
      check("free.overrun", 32'(overrun_b), 32'd0);
`endif
      // The start at k=3 launched a sweep on the one-shot instance; it ends by now.
      check_a("settle", 7, 0, 0);

      // Single sweep.
      start = 1'b1; tick(); start = 1'b0;
      check_a("sweep[0]", 7, 1, 0);
      for (int k = 1; k <= 7; k++) begin
         tick();
         check_a($sformatf("sweep[%0d]", k), 7 - k, 1, 0);
      end
      tick();
      check_a("sweep.end", 7, 0, 1);
      tick();
      check_a("sweep.after", 7, 0, 0);

      // Asynchronous reset mid-sweep.
      start = 1'b1; tick(); start = 1'b0;
      tick(); tick(); tick();
      check_a("mid.pre", 4, 1, 0);
      #2 reset = 1'b1;
      #1;
      check_a("mid.reset", 7, 0, 0);
      #1 reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         check_a($sformatf("mid.post[%0d]", k), 7, 0, 0);
      end

      // Stall for 3 cycles at contador = 5.
      start = 1'b1; tick(); start = 1'b0;
      tick(); tick();
      check_a("stall.pre", 5, 1, 0);
      enable = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check_a($sformatf("stall[%0d]", k), 5, 1, 0);
      end
      enable = 1'b1;
      for (int k = 4; k >= 0; k--) begin
         tick();
         check_a($sformatf("stall.run[%0d]", k), k, 1, 0);
      end
      tick();
      check_a("stall.end", 7, 0, 1);
      tick();

      // Back-to-back restart on the terminal cycle.
      start = 1'b1; tick(); start = 1'b0;
      for (int k = 6; k >= 0; k--) tick();
      check_a("b2b.term", 0, 1, 0);
      start = 1'b1; tick(); start = 1'b0;
      check_a("b2b.restart", 7, 1, 1);
      tick();
      check_a("b2b.next", 6, 1, 0);
      for (int k = 5; k >= 0; k--) tick();
      check_a("b2b.term2", 0, 1, 0);
      tick();
      check_a("b2b.end", 7, 0, 1);
      tick();

      // Start on a non-terminal cycle is ignored.
      start = 1'b1; tick(); start = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      check_a("ovr.pre", 3, 1, 0);
      start = 1'b1; tick(); start = 1'b0;
      check_a("ovr.ignored", 2, 1, 0);
`ifdef FIR_SEQ_OVERRUN_EN
      check("ovr.set", 32'(overrun_a), 32'd1);
`endif
      tick(); tick();
      check_a("ovr.cont", 0, 1, 0);
`ifdef FIR_SEQ_OVERRUN_EN
      check("ovr.sticky", 32'(overrun_a), 32'd1);
      ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
      check("ovr.clr", 32'(overrun_a), 32'd0);
`else
      tick();
`endif
      check_a("ovr.end", 7, 0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
